// File: rtl/nhan_dang_xung.sv
// nhan_dang_xung: identifies which of four pulse rates is present on xi by
// measuring the clki-cycle period between rising edges, locking onto a code
// once LOCK_CNT consecutive periods agree, and flagging loss of the input.
// Optional feature: define NHAN_DANG_XUNG_DUTY_EN to also require a ~50% duty
// cycle for a period to match; otherwise duty_ok is held at 1.
module nhan_dang_xung #(
   parameter int P0       = 50_000_000,
   parameter int P1       = 25_000_000,
   parameter int P2       = 12_500_000,
   parameter int P3       = 6_250_000,
   parameter int TOL      = 1000,
   parameter int LOCK_CNT = 2,
   parameter int TIMEOUT  = 100_000_000
) (
   input  logic       clki,
   input  logic       rstn,
   input  logic       xi,
   output logic [1:0] S,
   output logic       valid,
   output logic       lost,
   output logic       duty_ok
);

   localparam logic [31:0] TIMEOUT_V = 32'(TIMEOUT);
   localparam logic [31:0] TOL_V     = 32'(TOL);
   localparam logic [31:0] LOCK_V    = 32'(LOCK_CNT);
   localparam logic [31:0] PER [4]   = '{32'(P0), 32'(P1), 32'(P2), 32'(P3)};

   typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, LOST} state_t;

   logic        sync1_reg, sync2_reg, sync3_reg, edge_reg;
   logic [31:0] cnt_reg, cnt_next;
   logic [31:0] match_reg, match_next;
   logic [1:0]  cand_reg, cand_next;
   logic [1:0]  s_reg, s_next;
   logic        valid_reg, valid_next;
   logic        lost_reg, lost_next;
   logic        duty_reg, duty_next;
   state_t      state_reg, state_next;

   logic [3:0]  hit;
   logic        cls_hit;
   logic [1:0]  cls_code;
   logic        duty_pass;
   logic        good;
   logic        sat;

   // Two-flop synchronizer, one extra stage for edge detect, registered edge pulse
   always_ff @(posedge clki) begin
      if (!rstn) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         sync3_reg <= 1'b0;
         edge_reg  <= 1'b0;
      end else begin
         sync1_reg <= xi;
         sync2_reg <= sync1_reg;
         sync3_reg <= sync2_reg;
         edge_reg  <= sync2_reg & ~sync3_reg;
      end
   end

   // Tolerance window per code: |period - Pc| <= TOL
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_win
         logic [31:0] diff;
         assign diff    = (cnt_reg >= PER[gi]) ? (cnt_reg - PER[gi]) : (PER[gi] - cnt_reg);
         assign hit[gi] = (diff <= TOL_V);
      end
   endgenerate

   // Priority select of the classified code; the lowest matching code wins
   always_comb begin
      cls_hit  = 1'b0;
      cls_code = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (hit[i]) begin
            cls_hit  = 1'b1;
            cls_code = 2'(i);
         end
      end
   end

`ifdef NHAN_DANG_XUNG_DUTY_EN
   localparam logic [31:0] TOL2_V = 32'(2 * TOL);

   logic [31:0] high_reg, high_next;
   logic [31:0] high2;
   logic [31:0] duty_diff;

   assign high2     = high_reg << 1;
   assign duty_diff = (high2 >= cnt_reg) ? (high2 - cnt_reg) : (cnt_reg - high2);
   assign duty_pass = (duty_diff <= TOL2_V);

   // High-time counter; the edge cycle itself is the first high cycle of the new period
   always_comb begin
      high_next = high_reg;
      if (edge_reg)
         high_next = 32'd1;
      else if (sync3_reg && (high_reg < TIMEOUT_V))
         high_next = high_reg + 32'd1;
   end

   // High-time counter register
   always_ff @(posedge clki) begin
      if (!rstn)
         high_reg <= 32'd0;
      else
         high_reg <= high_next;
   end
`else
   assign duty_pass = 1'b1;
`endif

   assign good = cls_hit & duty_pass;
   assign sat  = (cnt_reg >= TIMEOUT_V);

   // Period counter: restarts at 1 on each edge, idle before the first edge, saturates at TIMEOUT
   always_comb begin
      cnt_next = cnt_reg;
      if (edge_reg)
         cnt_next = 32'd1;
      else if (state_reg == IDLE)
         cnt_next = 32'd0;
      else if (cnt_reg < TIMEOUT_V)
         cnt_next = cnt_reg + 32'd1;
   end

   // Next-state and output logic of the lock FSM
   always_comb begin
      state_next = state_reg;
      match_next = match_reg;
      cand_next  = cand_reg;
      s_next     = s_reg;
      valid_next = valid_reg;
      lost_next  = lost_reg;
      duty_next  = duty_reg;
      case (state_reg)
         IDLE: begin
            if (edge_reg) begin
               state_next = MEASURE;
               match_next = 32'd0;
            end
         end
         MEASURE: begin
            if (edge_reg) begin
               duty_next = duty_pass;
               if (good) begin
                  if (cls_code == cand_reg) begin
                     match_next = match_reg + 32'd1;
                  end else begin
                     cand_next  = cls_code;
                     match_next = 32'd1;
                  end
                  if (((cls_code == cand_reg) ? (match_reg + 32'd1) : 32'd1) >= LOCK_V) begin
                     state_next = LOCKED;
                     s_next     = cls_code;
                     valid_next = 1'b1;
                  end
               end else begin
                  match_next = 32'd0;
               end
            end else if (sat) begin
               state_next = LOST;
               lost_next  = 1'b1;
               valid_next = 1'b0;
            end
         end
         LOCKED: begin
            if (edge_reg) begin
               duty_next = duty_pass;
               if (!(good && (cls_code == s_reg))) begin
                  state_next = MEASURE;
                  valid_next = 1'b0;
                  if (good) begin
                     cand_next  = cls_code;
                     match_next = 32'd1;
                  end else begin
                     match_next = 32'd0;
                  end
               end
            end else if (sat) begin
               state_next = LOST;
               lost_next  = 1'b1;
               valid_next = 1'b0;
            end
         end
         LOST: begin
            if (edge_reg) begin
               state_next = MEASURE;
               lost_next  = 1'b0;
               match_next = 32'd0;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, counter and output registers
   always_ff @(posedge clki) begin
      if (!rstn) begin
         state_reg <= IDLE;
         cnt_reg   <= 32'd0;
         match_reg <= 32'd0;
         cand_reg  <= 2'd0;
         s_reg     <= 2'd0;
         valid_reg <= 1'b0;
         lost_reg  <= 1'b0;
         duty_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         match_reg <= match_next;
         cand_reg  <= cand_next;
         s_reg     <= s_next;
         valid_reg <= valid_next;
         lost_reg  <= lost_next;
         duty_reg  <= duty_next;
      end
   end

   assign S       = s_reg;
   assign valid   = valid_reg;
   assign lost    = lost_reg;
   assign duty_ok = duty_reg;

endmodule

// File: tb/tb_nhan_dang_xung.sv
// Testbench for nhan_dang_xung with small periods (P0=40, P1=20, P2=10, P3=5,
// TOL=1, LOCK_CNT=2, TIMEOUT=100). A period's classification takes effect at
// the rising edge that closes it, so table expectations lag one period behind.
module tb_nhan_dang_xung;

   logic       clki = 1'b0;
   logic       rstn;
   logic       xi;
   logic [1:0] S;
   logic       valid;
   logic       lost;
   logic       duty_ok;

   int tests = 0;
   int fails = 0;

   always #5 clki = ~clki;

   nhan_dang_xung #(
      .P0(40), .P1(20), .P2(10), .P3(5),
      .TOL(1), .LOCK_CNT(2), .TIMEOUT(100)
   ) dut (
      .clki(clki),
      .rstn(rstn),
      .xi(xi),
      .S(S),
      .valid(valid),
      .lost(lost),
      .duty_ok(duty_ok)
   );

   typedef struct {
      int         period;
      int         high;
      int         reps;
      logic       exp_valid;
      logic [1:0] exp_s;
      logic       exp_lost;
      logic       exp_duty;
   } vec_t;

   vec_t vecs[23];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic v, input logic [1:0] s,
                            input logic l, input logic d);
      check($sformatf("%s valid", tag), int'(valid), int'(v));
      check($sformatf("%s S", tag), int'(S), int'(s));
      check($sformatf("%s lost", tag), int'(lost), int'(l));
      check($sformatf("%s duty_ok", tag), int'(duty_ok), int'(d));
      $display("[TB] %s: valid=%0d S=%0d lost=%0d duty_ok=%0d", tag, valid, S, lost, duty_ok);
   endtask

   // One xi period starting with a rising edge; called and returns on a negedge
   task automatic run_period(input int p, input int h);
      xi = 1'b1;
      repeat (h) @(negedge clki);
      xi = 1'b0;
      repeat (p - h) @(negedge clki);
   endtask

   initial begin
      vecs[0]  = '{20, 10, 1, 1'b0, 2'd0, 1'b0, 1'b1};
      vecs[1]  = '{20, 10, 1, 1'b0, 2'd0, 1'b0, 1'b1};
      vecs[2]  = '{20, 10, 1, 1'b1, 2'd1, 1'b0, 1'b1};
      vecs[3]  = '{20, 10, 2, 1'b1, 2'd1, 1'b0, 1'b1};
      vecs[4]  = '{10,  5, 1, 1'b1, 2'd1, 1'b0, 1'b1};
      vecs[5]  = '{10,  5, 1, 1'b0, 2'd1, 1'b0, 1'b1};
      vecs[6]  = '{10,  5, 1, 1'b1, 2'd2, 1'b0, 1'b1};
      vecs[7]  = '{30, 15, 1, 1'b1, 2'd2, 1'b0, 1'b1};
      vecs[8]  = '{30, 15, 2, 1'b0, 2'd2, 1'b0, 1'b1};
      vecs[9]  = '{41, 20, 1, 1'b0, 2'd2, 1'b0, 1'b1};
      vecs[10] = '{41, 20, 1, 1'b0, 2'd2, 1'b0, 1'b1};
      vecs[11] = '{41, 20, 1, 1'b1, 2'd0, 1'b0, 1'b1};
      vecs[12] = '{39, 20, 1, 1'b1, 2'd0, 1'b0, 1'b1};
      vecs[13] = '{42, 21, 1, 1'b1, 2'd0, 1'b0, 1'b1};
      vecs[14] = '{42, 21, 1, 1'b0, 2'd0, 1'b0, 1'b1};
      vecs[15] = '{42, 21, 1, 1'b0, 2'd0, 1'b0, 1'b1};
      vecs[16] = '{ 5,  2, 1, 1'b0, 2'd0, 1'b0, 1'b1};
      vecs[17] = '{ 5,  2, 1, 1'b0, 2'd0, 1'b0, 1'b1};
      vecs[18] = '{ 5,  2, 1, 1'b1, 2'd3, 1'b0, 1'b1};
      vecs[19] = '{20, 10, 1, 1'b1, 2'd3, 1'b0, 1'b1};
      vecs[20] = '{20, 10, 1, 1'b0, 2'd3, 1'b0, 1'b1};
      vecs[21] = '{20, 10, 1, 1'b1, 2'd1, 1'b0, 1'b1};
      vecs[22] = '{20, 10, 1, 1'b1, 2'd1, 1'b0, 1'b1};

      // Reset state
      rstn = 1'b0;
      xi   = 1'b0;
      repeat (3) @(negedge clki);
      check_all("reset", 1'b0, 2'd0, 1'b0, 1'b1);
      rstn = 1'b1;

      // Table-driven period sequences
      for (int r = 0; r < 23; r++) begin
         for (int k = 0; k < vecs[r].reps; k++)
            run_period(vecs[r].period, vecs[r].high);
         check_all($sformatf("row %0d period=%0d x%0d", r, vecs[r].period, vecs[r].reps),
                   vecs[r].exp_valid, vecs[r].exp_s, vecs[r].exp_lost, vecs[r].exp_duty);
      end

      // Timeout: last rise was 20 negedges ago; loss is flagged 104 negedges after it
      repeat (83) @(negedge clki);
      check_all("timeout-1", 1'b1, 2'd1, 1'b0, 1'b1);
      @(negedge clki);
      check_all("timeout", 1'b0, 2'd1, 1'b1, 1'b1);
      repeat (20) @(negedge clki);
      check_all("timeout hold", 1'b0, 2'd1, 1'b1, 1'b1);

      // Recovery at period 5
      run_period(5, 2);
      check_all("resume edge1", 1'b0, 2'd1, 1'b0, 1'b1);
      run_period(5, 2);
      check_all("resume edge2", 1'b0, 2'd1, 1'b0, 1'b1);
      run_period(5, 2);
      check_all("resume edge3", 1'b1, 2'd3, 1'b0, 1'b1);

      // One-cycle reset while locked
      rstn = 1'b0;
      @(negedge clki);
      rstn = 1'b1;
      check_all("mid reset", 1'b0, 2'd0, 1'b0, 1'b1);
      run_period(20, 10);
      check_all("relock edge1", 1'b0, 2'd0, 1'b0, 1'b1);
      run_period(20, 10);
      check_all("relock edge2", 1'b0, 2'd0, 1'b0, 1'b1);
      run_period(20, 10);
      check_all("relock edge3", 1'b1, 2'd1, 1'b0, 1'b1);

      // Period 20 with high time 4
      repeat (3) run_period(20, 4);
`ifdef NHAN_DANG_XUNG_DUTY_EN
      check_all("duty 20/4", 1'b0, 2'd1, 1'b0, 1'b0);
      repeat (2) run_period(20, 4);
      check_all("duty 20/4 hold", 1'b0, 2'd1, 1'b0, 1'b0);
`else
      check_all("duty 20/4", 1'b1, 2'd1, 1'b0, 1'b1);
      repeat (2) run_period(20, 4);
      check_all("duty 20/4 hold", 1'b1, 2'd1, 1'b0, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/nhan_dang_xung.md
NHAN_DANG_XUNG -- requirements
Module: nhan_dang_xung

Interface
REQ-001 SHALL have parameter P0, default 50_000_000, expected clki cycles per xi period for code 0 (1 Hz).
REQ-002 SHALL have parameter P1, default 25_000_000, expected period for code 1 (2 Hz).
REQ-003 SHALL have parameter P2, default 12_500_000, expected period for code 2 (4 Hz).
REQ-004 SHALL have parameter P3, default 6_250_000, expected period for code 3 (8 Hz).
REQ-005 SHALL have parameter TOL, default 1000, allowed period deviation, +/- cycles, inclusive.
REQ-006 SHALL have parameter LOCK_CNT, default 2, consecutive matching periods required to lock.
REQ-007 SHALL have parameter TIMEOUT, default 100_000_000, cycles without a rising edge before loss is declared.
REQ-008 SHALL have port clki, input, 1 bit: the single clock, 50 MHz nominal.
REQ-009 SHALL have port rstn, input, 1 bit: synchronous, active-low reset.
REQ-010 SHALL have port xi, input, 1 bit: asynchronous pulse train from the selectable pulse generator.
REQ-011 SHALL have port S, output, 2 bits: decoded selection code.
REQ-012 SHALL have port valid, output, 1 bit: S is locked and trustworthy.
REQ-013 SHALL have port lost, output, 1 bit: no xi edge for TIMEOUT cycles (generator disabled or stuck).
REQ-014 SHALL have port duty_ok, output, 1 bit: last period passed the duty check (see Configuration).

Function
REQ-015 SHALL pass xi through a 2-flop synchronizer and detect rising edges on the synchronized signal (edge pulse 3 clki cycles after an xi transition).
REQ-016 SHALL count clki cycles in a 32-bit counter; on each detected edge, the count is the measured period and the counter restarts at 1; the counter saturates at TIMEOUT.
REQ-017 SHALL classify the measured period as code c when |period - Pc| <= TOL; when windows overlap, the lowest code wins; otherwise the period is unclassified.
REQ-018 SHALL implement states IDLE, MEASURE, LOCKED and LOST; reset enters IDLE.
REQ-019 In IDLE: the first edge only starts the counter (no classification) and moves to MEASURE.
REQ-020 In MEASURE: on an edge, a classified period equal to the candidate increments the match count; a different class makes it the new candidate with count 1; an unclassified period sets count 0.
REQ-021 In MEASURE: when the match count reaches LOCK_CNT, SHALL move to LOCKED, load S with the candidate and assert valid.
REQ-022 In LOCKED: an edge with a period classified as S stays locked; any other period returns to MEASURE, deasserts valid, holds S, and seeds the candidate per REQ-020.
REQ-023 In MEASURE or LOCKED: when the counter reaches TIMEOUT, SHALL enter LOST with lost=1 and valid=0.
REQ-024 In LOST: the next edge clears lost, restarts the counter, and enters MEASURE with match count 0.
REQ-025 S, valid, lost and duty_ok SHALL update on the clki edge following the detected-edge cycle (1-cycle latency), and SHALL be registered.
REQ-026 Constant xi (high or low) SHALL produce no edges and therefore lead to LOST.

Reset
REQ-027 While rstn=0 at a clki edge: state=IDLE, S=0, valid=0, lost=0, duty_ok=1, counters and candidate cleared, synchronizer flops cleared.
REQ-028 Reset asserted mid-measurement SHALL discard all partial measurements; the first edge after release is treated per REQ-019.

Configuration
REQ-029 Macro NHAN_DANG_XUNG_DUTY_EN, when defined: SHALL also count synchronized-high cycles per period; a period matches only if |high*2 - period| <= 2*TOL; duty_ok reflects that check on every edge.
REQ-030 Without NHAN_DANG_XUNG_DUTY_EN: no high-time counter exists, duty is ignored, and duty_ok is tied to 1.

Verification (overrides: P0=40, P1=20, P2=10, P3=5, TOL=1, LOCK_CNT=2, TIMEOUT=100)
REQ-031 Use a 50% square wave on xi with period 20 clki -> after 3 edges: valid=1, S=1, lost=0.
REQ-032 While locked at period 20, switch to period 10 -> valid=0 on the next edge; valid=1 with S=2 after two further period-10 edges.
REQ-033 Use a period of 30 (unclassified) -> valid stays 0, S holds its previous value; a period of 41 is classified as code 0 (tolerance edge), and 42 is not.
REQ-034 Hold xi low for 100 cycles while locked -> lost=1 and valid=0 exactly at saturation; resume with period 5 -> lost=0 on the first edge, then S=3 and valid=1 after 2 further edges.
REQ-035 Pulse rstn=0 for one cycle while locked -> S=0, valid=0, lost=0 next cycle; relock requires LOCK_CNT+1 edges.
REQ-036 With NHAN_DANG_XUNG_DUTY_EN, use period 20 with high time 4 -> duty_ok=0 and no lock; without the macro the same stimulus locks to S=1.
